// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: FSM states and default timing shared by the HC-SR04 responder and ranging master
package hcsr04_pkg;
    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;
    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_TRIG_MIN_CYC = 500;
    localparam int DEF_BURST_CYC    = 10_000;
    localparam int DEF_CYC_PER_CM   = 2_900;
    localparam int DEF_MAX_CM       = 400;
    localparam int DEF_TIMEOUT_CYC  = 1_900_000;
    localparam int DEF_HOLDOFF_CYC  = 500_000;
    localparam int CNT_W            = 21;
endpackage

// File: rtl/trig_sync.sv
// trig_sync: two-flop synchronizer for trig with rise/fall detect on the synchronized level
// ports: clk, rst (async, active-high), trig (async in), rise/fall (one-cycle pulses)
module trig_sync (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic rise,
    output logic fall
);
    logic [2:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[1:0], trig};
    always_ff @(posedge clk or posedge rst)
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/hcsr04_responder.sv
// hcsr04_responder: emulates an HC-SR04 ultrasonic sensor answering trig with a distance-coded echo
// ports: clk, rst (async, active-high), enable, trig (async), distance_cm[8:0] in;
//        echo (registered pulse), busy (state != IDLE), trig_err (one-cycle short-trigger pulse) out
module hcsr04_responder import hcsr04_pkg::*; #(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int TRIG_MIN_CYC = DEF_TRIG_MIN_CYC,
    parameter int BURST_CYC    = DEF_BURST_CYC,
    parameter int CYC_PER_CM   = DEF_CYC_PER_CM,
    parameter int MAX_CM       = DEF_MAX_CM,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int HOLDOFF_CYC  = DEF_HOLDOFF_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);
    if (CLK_HZ <= 0) begin : g_bad_clk
        $error("CLK_HZ must be positive");
    end
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, width_q, width_d;
    logic [8:0]         dist_q, dist_d;
    logic               echo_q, echo_d, err_q, err_d;
    logic               rise, fall, short_trig, in_range;
    trig_sync u_sync (.clk(clk), .rst(rst), .trig(trig), .rise(rise), .fall(fall));
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dist_d     = dist_q;
        width_d    = width_q;
        err_d      = 1'b0;
        short_trig = cnt_q < CNT_W'(TRIG_MIN_CYC);
        in_range   = dist_q != 9'd0 && 32'(dist_q) <= MAX_CM;
        case (state_q)
            IDLE: if (rise) begin
                state_d = TRIG_HI;
                cnt_d   = CNT_W'(1);
            end
            // The rise cycle already counted one high cycle; saturate so an endless trig cannot wrap
            TRIG_HI: if (fall) begin
                state_d = short_trig ? IDLE : BURST;
                err_d   = short_trig;
                dist_d  = short_trig ? dist_q : distance_cm;
                cnt_d   = '0;
            end else begin
                cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            end
            // Distance is frozen here, so the width settles well before ECHO consumes it
            BURST: begin
                width_d = in_range ? CNT_W'(32'(dist_q) * 32'(CYC_PER_CM)) : CNT_W'(TIMEOUT_CYC);
                state_d = cnt_q == CNT_W'(BURST_CYC - 1) ? ECHO : BURST;
                cnt_d   = cnt_q == CNT_W'(BURST_CYC - 1) ? '0 : cnt_q + 1'b1;
            end
            ECHO: begin
                state_d = cnt_q == width_q - 1'b1 ? HOLDOFF : ECHO;
                cnt_d   = cnt_q == width_q - 1'b1 ? '0 : cnt_q + 1'b1;
            end
            HOLDOFF: begin
                state_d = cnt_q == CNT_W'(HOLDOFF_CYC - 1) ? IDLE : HOLDOFF;
                cnt_d   = cnt_q == CNT_W'(HOLDOFF_CYC - 1) ? '0 : cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
        echo_d = state_d == ECHO;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            width_q <= '0;
            dist_q  <= '0;
            echo_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            dist_q  <= dist_d;
            echo_q  <= echo_d;
            err_q   <= err_d;
        end
    assign echo     = echo_q;
    assign busy     = state_q != IDLE;
    assign trig_err = err_q;
endmodule

// File: tb/tb_hcsr04_responder.sv
// tb_hcsr04_responder: directed self-checking bench for hcsr04_responder with shortened timing
module tb_hcsr04_responder;
    logic       clk = 1'b0;
    logic       rst, enable, trig;
    logic [8:0] distance_cm;
    logic       echo, busy, trig_err;
    logic       echo_prev = 1'b0;
    int         checks = 0, failures = 0, err_cnt = 0, rise_cnt = 0;

    always #5 clk = ~clk;

    hcsr04_responder #(
        .TRIG_MIN_CYC(5), .BURST_CYC(20), .CYC_PER_CM(10), .MAX_CM(400),
        .TIMEOUT_CYC(5000), .HOLDOFF_CYC(50)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .trig(trig), .distance_cm(distance_cm),
        .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    always @(negedge clk) begin
        if (trig_err) err_cnt++;
        if (echo && !echo_prev) rise_cnt++;
        echo_prev = echo;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input int n);
        @(negedge clk);
        trig = 1'b1;
        repeat (n) @(negedge clk);
        trig = 1'b0;
    endtask

    // r: edges from trig release to echo rise (2 sync + 1 decode + 20 burst = 23),
    // w: echo-high edges, h: edges from echo fall until busy drops
    task automatic measure(output int r, output int w, output int h);
        r = 0; w = 0; h = 0;
        while (!echo && r < 200) begin @(posedge clk); #1; r++; end
        while (echo && w < 6000) begin @(posedge clk); #1; w++; end
        while (busy && h < 200) begin @(posedge clk); #1; h++; end
    endtask

    int r, w, h, e0, r0, n;
    int dists [3] = '{0, 450, 400};
    int widths[3] = '{5000, 5000, 4000};

    initial begin
        rst = 1'b1; enable = 1'b1; trig = 1'b0; distance_cm = 9'd25;
        repeat (3) @(negedge clk);
        check("rst_echo", echo, 0);
        check("rst_busy", busy, 0);
        check("rst_err", trig_err, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        pulse(8);
        measure(r, w, h);
        check("d25_rise", r, 23);
        check("d25_width", w, 250);
        check("d25_holdoff", h, 50);

        e0 = err_cnt; r0 = rise_cnt;
        pulse(3);
        repeat (20) @(negedge clk);
        check("short_err", err_cnt - e0, 1);
        check("short_noecho", rise_cnt - r0, 0);
        check("short_busy", busy, 0);

        e0 = err_cnt;
        pulse(4);
        repeat (20) @(negedge clk);
        check("min_m1_err", err_cnt - e0, 1);
        distance_cm = 9'd1;
        pulse(5);
        measure(r, w, h);
        check("min_width", w, 10);

        for (int i = 0; i < 3; i++) begin
            repeat (3) @(negedge clk);
            distance_cm = 9'(dists[i]);
            pulse(8);
            measure(r, w, h);
            check($sformatf("width_d%0d", dists[i]), w, widths[i]);
        end

        repeat (3) @(negedge clk);
        distance_cm = 9'd25;
        e0 = err_cnt; r0 = rise_cnt;
        pulse(8);
        fork
            measure(r, w, h);
            begin
                repeat (10) @(posedge clk);
                distance_cm = 9'd100;
                n = 0;
                while (!echo && n < 200) begin @(negedge clk); n++; end
                repeat (50) @(negedge clk);
                pulse(8);
                n = 0;
                while (echo && n < 6000) begin @(negedge clk); n++; end
                repeat (10) @(negedge clk);
                pulse(8);
            end
        join
        check("late_d_width", w, 250);
        check("late_d_rise", r, 23);
        check("late_d_holdoff", h, 50);
        repeat (30) @(negedge clk);
        check("ignored_err", err_cnt - e0, 0);
        check("ignored_restart", rise_cnt - r0, 1);
        check("ignored_busy", busy, 0);

        pulse(8);
        n = 0;
        while (!echo && n < 200) begin @(negedge clk); n++; end
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst_echo", echo, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        r0 = rise_cnt;
        pulse(8);
        repeat (8) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        #1 check("disable_busy", busy, 0);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (60) @(negedge clk);
        check("disable_noresume", busy, 0);
        check("disable_noecho", rise_cnt - r0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
